// File: rtl/axi_pkg.sv
// Shared definitions for the SRAM-like to AXI3 bridges: FSM states,
// AXI encodings and the fixed tie-off values for single-beat transfers.
package axi_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_ADDR = 3'd3,
      WR_RESP = 3'd4
   } bridge_state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   localparam logic [7:0] LEN_SINGLE    = 8'd0;
   localparam logic [1:0] LOCK_NORMAL   = 2'b00;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0000;
   localparam logic [2:0] PROT_DEFAULT  = 3'b000;

   // Port size code 3 has no meaning upstream and is issued as a word.
   function automatic logic [2:0] axi_size(input logic [1:0] size);
      case (size)
         2'd0:    return SIZE_BYTE;
         2'd1:    return SIZE_HALF;
         default: return SIZE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/axi_strb_gen.sv
// Byte-lane strobe decoder from transfer size and the low address bits;
// shared by the data-side and instruction-side bridges.
module axi_strb_gen (
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] strb
);

   always_comb begin
      strb = 4'b1111;
      case (size)
         2'd0:    strb = 4'b0001 << addr_lo;
         2'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
         default: strb = 4'b1111;
      endcase
   end

endmodule

// File: rtl/data_axi_bridge.sv
// Data-port bridge: one SRAM-like request at a time is turned into a
// single-beat AXI3 read or write; AW and W are issued in parallel.
module data_axi_bridge
   import axi_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'd1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          data_req,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [31:0]   data_addr,
   input  logic [31:0]   data_wdata,
   output logic [31:0]   data_rdata,
   output logic          data_addr_ok,
   output logic          data_data_ok,
   output logic [3:0]    arid,
   output logic [31:0]   araddr,
   output logic [7:0]    arlen,
   output logic [2:0]    arsize,
   output logic [1:0]    arburst,
   output logic [1:0]    arlock,
   output logic [3:0]    arcache,
   output logic [2:0]    arprot,
   output logic          arvalid,
   input  logic          arready,
   input  logic [3:0]    rid,
   input  logic [31:0]   rdata,
   input  logic [1:0]    rresp,
   input  logic          rlast,
   input  logic          rvalid,
   output logic          rready,
   output logic [3:0]    awid,
   output logic [31:0]   awaddr,
   output logic [7:0]    awlen,
   output logic [2:0]    awsize,
   output logic [1:0]    awburst,
   output logic [1:0]    awlock,
   output logic [3:0]    awcache,
   output logic [2:0]    awprot,
   output logic          awvalid,
   input  logic          awready,
   output logic [3:0]    wid,
   output logic [31:0]   wdata,
   output logic [3:0]    wstrb,
   output logic          wlast,
   output logic          wvalid,
   input  logic          wready,
   input  logic [3:0]    bid,
   input  logic [1:0]    bresp,
   input  logic          bvalid,
   output logic          bready,
   output bridge_state_e fsm_state
);

   // Every AXI valid holds until its ready is seen on a rising edge, and the
   // latched request fields feeding it stay frozen until then.
   bridge_state_e state, state_nxt;

   logic        req_wr;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        aw_done, w_done;
   logic        aw_fin, w_fin;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      data_addr_ok = 1'b0;
      arvalid      = 1'b0;
      rready       = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      bready       = 1'b0;
      aw_fin       = aw_done | awready;
      w_fin        = w_done | wready;
      case (state)
         IDLE: begin
            data_addr_ok = 1'b1;
            if (data_req) state_nxt = data_wr ? WR_ADDR : RD_ADDR;
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            rready = 1'b1;
            if (rvalid) state_nxt = IDLE;
         end
         WR_ADDR: begin
            awvalid = ~aw_done;
            wvalid  = ~w_done;
            if (aw_fin && w_fin) state_nxt = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_wr    <= 1'b0;
         req_size  <= 2'd0;
         req_addr  <= 32'd0;
         req_wdata <= 32'd0;
      end else if (state == IDLE && data_req) begin
         req_wr    <= data_wr;
         req_size  <= data_size;
         req_addr  <= data_addr;
         req_wdata <= data_wdata;
      end
   end

   // Done flags only live inside WR_ADDR, so each write starts with both clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         aw_done <= (state == WR_ADDR) && (state_nxt == WR_ADDR) && aw_fin;
         w_done  <= (state == WR_ADDR) && (state_nxt == WR_ADDR) && w_fin;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_rdata   <= 32'd0;
         data_data_ok <= 1'b0;
      end else begin
         data_data_ok <= (state == RD_DATA && rvalid) || (state == WR_RESP && bvalid);
         if (state == RD_DATA && rvalid) data_rdata <= rdata;
      end
   end

   axi_strb_gen u_strb_gen (
      .size    (req_size),
      .addr_lo (req_addr[1:0]),
      .strb    (wstrb)
   );

   assign araddr = req_addr;
   assign awaddr = req_addr;
   assign arsize = axi_size(req_size);
   assign awsize = axi_size(req_size);
   assign wdata  = req_wdata;
   assign wlast  = wvalid;

   assign arid    = AXI_ID;
   assign awid    = AXI_ID;
   assign wid     = AXI_ID;
   assign arlen   = LEN_SINGLE;
   assign awlen   = LEN_SINGLE;
   assign arburst = BURST_INCR;
   assign awburst = BURST_INCR;
   assign arlock  = LOCK_NORMAL;
   assign awlock  = LOCK_NORMAL;
   assign arcache = CACHE_DEFAULT;
   assign awcache = CACHE_DEFAULT;
   assign arprot  = PROT_DEFAULT;
   assign awprot  = PROT_DEFAULT;

   assign fsm_state = state;

   // Responses carry no error reporting and every burst is one beat.
   logic unused_inputs;
   assign unused_inputs = ^{rid, rresp, rlast, bid, bresp, req_wr};

endmodule

// File: tb/tb_data_axi_bridge.sv
// Bench for data_axi_bridge: directed scenarios plus random traffic against
// a cycle-level AXI slave and a behavioural transaction model.
`timescale 1ns/1ps
module tb_data_axi_bridge;
   import axi_pkg::*;

   localparam logic [3:0] AXI_ID = 4'd1;

   logic          clk = 1'b0;
   logic          resetn;
   logic          data_req, data_wr;
   logic [1:0]    data_size;
   logic [31:0]   data_addr, data_wdata, data_rdata;
   logic          data_addr_ok, data_data_ok;
   logic [3:0]    arid, awid, wid, rid, bid;
   logic [31:0]   araddr, awaddr, rdata, wdata;
   logic [7:0]    arlen, awlen;
   logic [2:0]    arsize, awsize, arprot, awprot;
   logic [1:0]    arburst, awburst, arlock, awlock, rresp, bresp;
   logic [3:0]    arcache, awcache, wstrb;
   logic          arvalid, arready, rlast, rvalid, rready;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   bridge_state_e fsm_state;

   always #5 clk = ~clk;

   data_axi_bridge #(.AXI_ID(AXI_ID)) dut (
      .clk(clk), .resetn(resetn),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .fsm_state(fsm_state)
   );

   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference rules, written from the port-level description.
   function automatic logic [31:0] ref_size(input logic [1:0] size);
      return (size == 2'd3) ? 32'd2 : 32'(size);
   endfunction

   function automatic logic [31:0] ref_strb(input logic [1:0] size, input logic [31:0] addr);
      int lane;
      lane = int'(addr % 4);
      case (size)
         2'd0:    return 32'(1 << lane);
         2'd1:    return (lane >= 2) ? 32'hC : 32'h3;
         default: return 32'hF;
      endcase
   endfunction

   task automatic clear_axi();
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      rvalid  = 1'b0; bvalid  = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_arvalid"}, 32'(arvalid), 32'd0);
      check({tag, "_rready"},  32'(rready),  32'd0);
      check({tag, "_awvalid"}, 32'(awvalid), 32'd0);
      check({tag, "_wvalid"},  32'(wvalid),  32'd0);
      check({tag, "_bready"},  32'(bready),  32'd0);
      check({tag, "_data_ok"}, 32'(data_data_ok), 32'd0);
      check({tag, "_rdata"},   data_rdata,   32'd0);
   endtask

   task automatic idle(input int n);
      data_req = 1'b0;
      repeat (n) begin
         @(negedge clk);
         check("idle_addr_ok", 32'(data_addr_ok), 32'd1);
         check("idle_data_ok", 32'(data_data_ok), 32'd0);
      end
   endtask

   // Called at a negedge; returns at the negedge of the data_ok cycle (or
   // just after a mid-flight reset) so a following call lands in that cycle.
   // a_dly: AR/AW ready delay, d_dly: W ready delay, r_dly: R/B valid delay.
   task automatic run_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int a_dly, input int d_dly,
                          input int r_dly, input bit hold, input int abort_at);
      bit a_done, d_done, a_hs, d_hs, resp_hs, resp_prev, finished;
      int a_wait, d_wait, r_wait, c, exp_lat;
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
      check("accept_addr_ok", 32'(data_addr_ok), 32'd1);
      @(posedge clk);
      a_done = 1'b0; d_done = !wr; resp_prev = 1'b0; finished = 1'b0;
      a_wait = 0; d_wait = 0; r_wait = 0; c = 0;
      exp_lat = 3 + r_dly + (wr ? ((a_dly > d_dly) ? a_dly : d_dly) : a_dly);
      while (!finished) begin
         @(negedge clk);
         c++;
         clear_axi();
         rdata = $urandom;
         if (!hold) begin
            data_req = 1'b0; data_wr = 1'($urandom); data_size = 2'($urandom);
            data_addr = $urandom; data_wdata = $urandom;
         end
         if (abort_at == c) begin
            data_req = 1'b0;
            resetn = 1'b0;
            #1;
            check_quiet("abort");
            @(negedge clk);
            resetn = 1'b1;
            #1;
            check("abort_addr_ok", 32'(data_addr_ok), 32'd1);
            exp_q.delete();
            finished = 1'b1;
         end else if (resp_prev) begin
            check("data_ok", 32'(data_data_ok), 32'd1);
            check("latency", 32'(c), 32'(exp_lat));
            check("ok_cycle_addr_ok", 32'(data_addr_ok), 32'd1);
            if (!wr) begin
               if (exp_q.size() > 0) check("data_rdata", data_rdata, exp_q.pop_front());
               else check("sb_underflow", 32'd1, 32'd0);
            end
            finished = 1'b1;
         end else begin
            check("data_ok_early", 32'(data_data_ok), 32'd0);
            check("busy_addr_ok", 32'(data_addr_ok), 32'd0);
            a_hs = 1'b0; d_hs = 1'b0; resp_hs = 1'b0;
            if (!wr) begin
               check("arvalid", 32'(arvalid), 32'(!a_done));
               check("rready",  32'(rready),  32'(a_done));
               if (!a_done) begin
                  check("araddr", araddr, addr);
                  check("arsize", 32'(arsize), ref_size(size));
                  arready = (a_wait >= a_dly);
                  a_wait++;
                  a_hs = arready;
               end else begin
                  rvalid = (r_wait >= r_dly);
                  r_wait++;
                  if (rvalid) begin
                     exp_q.push_back(rdata);
                     resp_hs = 1'b1;
                  end
               end
            end else begin
               check("awvalid", 32'(awvalid), 32'(!a_done));
               check("wvalid",  32'(wvalid),  32'(!d_done));
               check("wlast",   32'(wlast),   32'(!d_done));
               check("bready",  32'(bready),  32'(a_done && d_done));
               if (!a_done) begin
                  check("awaddr", awaddr, addr);
                  check("awsize", 32'(awsize), ref_size(size));
                  awready = (a_wait >= a_dly);
                  a_wait++;
                  a_hs = awready;
               end
               if (!d_done) begin
                  check("wdata", wdata, wd);
                  check("wstrb", 32'(wstrb), ref_strb(size, addr));
                  wready = (d_wait >= d_dly);
                  d_wait++;
                  d_hs = wready;
               end
               if (a_done && d_done) begin
                  bvalid = (r_wait >= r_dly);
                  r_wait++;
                  resp_hs = bvalid;
               end
            end
            a_done    = a_done | a_hs;
            d_done    = d_done | d_hs;
            resp_prev = resp_hs;
            if (c > 100) begin
               check("timeout", 32'd1, 32'd0);
               finished = 1'b1;
            end
         end
      end
      clear_axi();
      data_req = 1'b0;
   endtask

   initial begin
      logic        r_wr;
      logic [1:0]  r_size;
      resetn = 1'b0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
      rid = AXI_ID; bid = AXI_ID; rresp = 2'd0; bresp = 2'd0; rlast = 1'b1; rdata = 32'd0;
      clear_axi();
      repeat (3) @(negedge clk);
      check_quiet("reset");
      check("reset_araddr", araddr, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("post_reset_addr_ok", 32'(data_addr_ok), 32'd1);
      check("ids", 32'({arid, awid, wid}), 32'({AXI_ID, AXI_ID, AXI_ID}));
      check("lens", 32'({arlen, awlen}), 32'd0);
      check("bursts", 32'({arburst, awburst}), 32'h5);
      check("lock_cache_prot", 32'({arlock, awlock, arcache, awcache, arprot, awprot}), 32'd0);

      // Plan scenarios: word read, byte write, W before AW, back-to-back.
      rdata = 32'hDEADBEEF;
      run_txn(1'b0, 2'd2, 32'h1FC0_0000, 32'd0, 0, 0, 0, 1'b0, 0);
      idle(2);
      run_txn(1'b1, 2'd0, 32'h0000_0003, 32'hAB00_0000, 0, 0, 1, 1'b0, 0);
      idle(1);
      run_txn(1'b1, 2'd2, 32'h0000_1000, 32'h1234_5678, 3, 0, 0, 1'b0, 0);
      idle(1);
      run_txn(1'b0, 2'd2, 32'h0000_2000, 32'd0, 1, 0, 2, 1'b0, 0);
      run_txn(1'b1, 2'd1, 32'h0000_0002, 32'hCAFE_0000, 0, 0, 0, 1'b0, 0);
      run_txn(1'b1, 2'd3, 32'h0000_0005, 32'h0BAD_F00D, 0, 2, 0, 1'b0, 0);
      idle(1);

      // Request held high while AR stalls for 10 cycles.
      run_txn(1'b0, 2'd1, 32'h8000_0042, 32'd0, 10, 0, 0, 1'b1, 0);
      idle(1);

      // Reset while waiting for read data, then a fresh read.
      run_txn(1'b0, 2'd2, 32'h0000_3000, 32'd0, 0, 0, 0, 1'b0, 0);
      run_txn(1'b0, 2'd2, 32'h0000_4000, 32'd0, 0, 0, 10, 1'b0, 4);
      run_txn(1'b0, 2'd0, 32'h0000_4001, 32'd0, 0, 0, 1, 1'b0, 0);
      idle(1);

      for (int i = 0; i < 40; i++) begin
         r_wr   = 1'($urandom);
         r_size = 2'($urandom_range(0, 3));
         run_txn(r_wr, r_size, $urandom, $urandom, $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
